fifo_sync_late1: RTL and testbench

//  Synchronous single-clock FIFO with one-cycle read latency, built on a simple dual-port RAM.

---
 rtl/fifo_sync_pkg.sv | 17 +
 rtl/fifo_sync_late1_ram_sdp.sv | 53 +++++
 rtl/fifo_sync_late1.sv | 134 +++++++++++++
 tb/tb_fifo_sync_late1.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fifo_sync_pkg.sv
// rtl/fifo_sync_pkg.sv - shared constants and helpers for the synchronous FIFO family
//
// Purpose: default parameter values and the address-width to depth helper
//          used by fifo_sync_late1 and its RAM.
// Ports:   none (package)
package fifo_sync_pkg;

    localparam int DEF_ADDRWIDTH = 5;
    localparam int DEF_DATAWIDTH = 18;
    localparam int DEF_SLOP      = 4;

    // Number of words addressable with an address of the given width.
    function automatic int depth(input int addrwidth);
        return 1 << addrwidth;
    endfunction

endpackage

// File: rtl/fifo_sync_late1_ram_sdp.sv
// rtl/fifo_sync_late1_ram_sdp.sv - simple dual-port RAM with registered read-first port
//
// Purpose: DEPTH x DATAWIDTH storage for fifo_sync_late1. One write port, one
//          read port whose output register updates only on a read and is
//          cleared by reset. The array itself is never cleared.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (read register only)
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read strobe
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data
module ram_sdp
    import fifo_sync_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic [ADDRWIDTH-1:0] wr_addr_i,
    input  logic [DATAWIDTH-1:0] wr_data_i,
    input  logic                 rd_en_i,
    input  logic [ADDRWIDTH-1:0] rd_addr_i,
    output logic [DATAWIDTH-1:0] rd_data_o
);

    localparam int DEPTH = depth(ADDRWIDTH);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];
    logic [DATAWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking semantics make a same-address read return the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_late1.sv
// rtl/fifo_sync_late1.sv - single-clock FIFO with one-cycle read latency
//
// Purpose: bulk FIFO store with registered not-empty, almost-full and sticky
//          overflow/underflow flags on top of ram_sdp.
// Build option: FIFO_SYNC_LATE_FATAL_EN - when defined, simulation reports and
//          finishes on the first overflow or underflow.
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   wr_data  in   write data
//   we       in   write enable
//   ns_full  out  combinational next value of full
//   full     out  registered almost-full (count >= DEPTH-SLOP)
//   ovf      out  sticky overflow
//   rd_data  out  read data, valid the cycle after re
//   re       in   read enable
//   ne       out  registered not-empty
//   unf      out  sticky underflow
module fifo_sync_late1
    import fifo_sync_pkg::*;
#(
    parameter int ADDRWIDTH = DEF_ADDRWIDTH,
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int SLOP      = DEF_SLOP
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 we,
    output logic                 ns_full,
    output logic                 full,
    output logic                 ovf,
    output logic [DATAWIDTH-1:0] rd_data,
    input  logic                 re,
    output logic                 ne,
    output logic                 unf
);

    localparam int                 DEPTH    = depth(ADDRWIDTH);
    localparam logic [ADDRWIDTH:0] DEPTH_C  = (ADDRWIDTH+1)'(DEPTH);
    localparam logic [ADDRWIDTH:0] FULL_THR = (ADDRWIDTH+1)'(DEPTH - SLOP);

    logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]   count_q, count_d;
    logic                 ne_q, ne_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic is_empty, is_full;
    logic rd_ok, wr_ok;
    logic ovf_set, unf_set;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // When full, a simultaneous read frees the slot first, so the write is kept.
    assign rd_ok   = re && !is_empty;
    assign wr_ok   = we && (!is_full || rd_ok);
    assign ovf_set = we && is_full && !re;
    assign unf_set = re && is_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ne_d   = (count_d != '0);
        full_d = (count_d >= FULL_THR);
        ovf_d  = ovf_q || ovf_set;
        unf_d  = unf_q || unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ne_q     <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ne_q     <= ne_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    ram_sdp #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_ok && !reset),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_ok && !reset),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign ns_full = full_d;
    assign full    = full_q;
    assign ne      = ne_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

`ifdef FIFO_SYNC_LATE_FATAL_EN
    always @(posedge clk) begin
        if (!reset && ((ovf_set && !ovf_q) || (unf_set && !unf_q))) begin
            $display("%m FIFO overflow/underflow error");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_late1.sv
// tb/tb_fifo_sync_late1.sv - self-checking bench for fifo_sync_late1
module tb_fifo_sync_late1;

    localparam int AW    = 5;
    localparam int DW    = 18;
    localparam int SLOP  = 4;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic          ns_full, full, ovf, ne, unf;
    logic [DW-1:0] rd_data;

    int tests = 0;
    int fails = 0;

    // Reference model: a word queue plus the externally visible flags.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd;
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    fifo_sync_late1 #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .SLOP(SLOP)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_data (wr_data),
        .we      (we),
        .ns_full (ns_full),
        .full    (full),
        .ovf     (ovf),
        .rd_data (rd_data),
        .re      (re),
        .ne      (ne),
        .unf     (unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ns_full before the edge, advance the
    // model, then check registered outputs just after the edge.
    task automatic cyc(input logic r, input logic w, input logic rr, input logic [DW-1:0] d);
        int  cnt;
        bit  rd, wr;
        reset   = r;
        we      = w;
        re      = rr;
        wr_data = d;
        if (r) begin
            mq.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            cnt = mq.size();
            rd  = rr && cnt != 0;
            wr  = w && (cnt != DEPTH || rd);
            if (w && cnt == DEPTH && !rr) m_ovf = 1'b1;
            if (rr && cnt == 0) m_unf = 1'b1;
            if (rd) m_rd = mq.pop_front();
            if (wr) mq.push_back(d);
            @(negedge clk);
            chk("ns_full", {31'b0, ns_full}, {31'b0, mq.size() >= DEPTH - SLOP});
        end
        @(posedge clk);
        #1;
        chk("ne",      {31'b0, ne},   {31'b0, mq.size() != 0});
        chk("full",    {31'b0, full}, {31'b0, mq.size() >= DEPTH - SLOP});
        chk("ovf",     {31'b0, ovf},  {31'b0, m_ovf});
        chk("unf",     {31'b0, unf},  {31'b0, m_unf});
        chk("rd_data", {14'b0, rd_data}, {14'b0, m_rd});
    endtask

    initial begin
        // 1: reset then idle
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, '0);

        // 2: three writes then three reads
        cyc(0, 1, 0, 18'h11);
        chk("ne_after_first_write", {31'b0, ne}, 32'd1);
        cyc(0, 1, 0, 18'h22);
        cyc(0, 1, 0, 18'h33);
        cyc(0, 0, 1, '0);
        chk("rd0", {14'b0, rd_data}, 32'h11);
        cyc(0, 0, 1, '0);
        chk("rd1", {14'b0, rd_data}, 32'h22);
        cyc(0, 0, 1, '0);
        chk("rd2", {14'b0, rd_data}, 32'h33);
        chk("ne_after_drain", {31'b0, ne}, 32'd0);

        // 3: fill to threshold, to DEPTH, then one more with no read
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, DW'($urandom));
        chk("full_at_depth", {31'b0, full}, 32'd1);
        chk("no_ovf_at_depth", {31'b0, ovf}, 32'd0);
        cyc(0, 1, 0, 18'h3ffff);
        chk("ovf_set", {31'b0, ovf}, 32'd1);
        chk("count_stays", mq.size(), DEPTH);

        // 4: read+write while full (fresh reset so ovf starts clear)
        cyc(1, 0, 0, '0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, DW'(i + 100));
        cyc(0, 1, 1, 18'h2aaaa);
        chk("full_rw_oldest", {14'b0, rd_data}, 32'd100);
        chk("full_rw_no_ovf", {31'b0, ovf}, 32'd0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, '0);
        chk("full_rw_newest", {14'b0, rd_data}, 32'h2aaaa);

        // 5: underflow after reset
        cyc(1, 0, 0, '0);
        cyc(0, 0, 1, '0);
        chk("unf_set", {31'b0, unf}, 32'd1);
        chk("unf_rd_hold", {14'b0, rd_data}, 32'd0);
        cyc(0, 1, 0, 18'h155);
        cyc(0, 0, 1, '0);
        chk("unf_sticky", {31'b0, unf}, 32'd1);

        // 6: streaming around count ~5 with random gaps, then reset mid-stream
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, DW'($urandom));
        for (int i = 0; i < 100; i++) begin
            logic w, rr;
            w  = ($urandom_range(0, 7) != 0);
            rr = ($urandom_range(0, 7) != 0) && mq.size() != 0;
            if (mq.size() > 8) w = 1'b0;
            cyc(0, w, rr, DW'($urandom));
        end
        chk("stream_no_ovf", {31'b0, ovf}, 32'd0);
        cyc(1, 1, 1, DW'($urandom));
        chk("reset_mid_ne", {31'b0, ne}, 32'd0);
        cyc(0, 0, 0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
